io_timer_irq: RTL and testbench

Memory-mapped timer and interrupt source on the CPU16 I/O bus, acting as the bus responder to the CPU's `io_rd`/`io_wr` strobes. It counts prescaled clock ticks against a compare value and raises `interrupt` on a match. The interrupt is cleared by an I/O write to the acknowledge address or by write-1-to-clear in STATUS. It sits beside the CPU core in the top level and replaces the bench-level interrupt stub.

---
 rtl/cpu16_io_pkg.sv | 20 ++
 rtl/io_bus_slave_if.sv | 63 ++++++
 rtl/io_timer_irq.sv | 123 ++++++++++++
 tb/tb_io_timer_irq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu16_io_pkg.sv
// Shared definitions for CPU16 I/O-bus peripherals: register map, bit fields
// and the default interrupt-acknowledge address.
package cpu16_io_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [15:0] NUM_REGS    = 16'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IE      = 2;
  localparam int STAT_PENDING = 0;
  localparam int STAT_OVERRUN = 1;

  localparam logic [15:0] DEFAULT_ACK_ADDR = 16'h55AA;

endpackage

// File: rtl/io_bus_slave_if.sv
// Generic CPU16 I/O responder front end: latches writes until io_wr falls,
// then issues a one-cycle commit; registers read data for a one-cycle handshake.
module io_bus_slave_if
  import cpu16_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_address,
  input  logic [15:0] io_wdata,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [15:0] io_rdata,
  output logic        io_rvalid,
  output logic [2:0]  rd_off,
  input  logic [15:0] rd_data,
  output logic        wr_commit,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_hit,
  output logic [2:0]  wr_off
);

  logic        wr_q;
  logic [15:0] waddr_q, wdata_q, rdata_q;
  logic        rvalid_q;
  logic [15:0] rd_rel, wr_rel;
  logic        rd_hit;

  // Addresses below the base wrap to large offsets, so one compare suffices.
  assign rd_rel = io_address - BASE_ADDR;
  assign wr_rel = waddr_q - BASE_ADDR;
  assign rd_hit = rd_rel < NUM_REGS;
  assign rd_off = rd_rel[2:0];
  assign wr_hit = wr_rel < NUM_REGS;
  assign wr_off = wr_rel[2:0];

  assign wr_commit = wr_q & ~io_wr;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;
  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_q <= io_wr;
      if (io_wr) begin
        waddr_q <= io_address;
        wdata_q <= io_wdata;
      end
      rvalid_q <= io_rd & rd_hit;
      if (io_rd && rd_hit) rdata_q <= rd_data;
    end
  end

endmodule

// File: rtl/io_timer_irq.sv
// Prescaled compare timer with level interrupt, mapped on the CPU16 I/O bus.
// Interrupt clears via a write to ACK_ADDR or write-1-to-clear in STATUS.
module io_timer_irq
  import cpu16_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter logic [15:0] ACK_ADDR  = DEFAULT_ACK_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_address,
  input  logic [15:0] io_wdata,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [15:0] io_rdata,
  output logic        io_rvalid,
  output logic        interrupt
);

  logic        wr_commit, wr_hit;
  logic [15:0] wr_addr, wr_data, rd_data;
  logic [2:0]  wr_off, rd_off;

  io_bus_slave_if #(.BASE_ADDR(BASE_ADDR)) u_bus (
    .clk(clk), .reset(reset),
    .io_address(io_address), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
    .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .rd_off(rd_off), .rd_data(rd_data),
    .wr_commit(wr_commit), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_hit(wr_hit), .wr_off(wr_off)
  );

  logic        en_q, auto_q, ie_q, pending_q, overrun_q, irq_q;
  logic        en_d, auto_d, ie_d, pending_d, overrun_d;
  logic [15:0] prescale_q, compare_q, count_q, pre_q;
  logic [15:0] prescale_d, compare_d, count_d, pre_d;
  logic        tick, match, reg_wr, ack;

  assign tick   = en_q && (pre_q == prescale_q);
  assign match  = tick && (count_q == compare_q);
  assign reg_wr = wr_commit && wr_hit;
  assign ack    = wr_commit && (wr_addr == ACK_ADDR);
  assign interrupt = irq_q;

  always_comb begin
    rd_data = '0;
    case (rd_off)
      REG_CTRL:     rd_data = {13'd0, ie_q, auto_q, en_q};
      REG_PRESCALE: rd_data = prescale_q;
      REG_COMPARE:  rd_data = compare_q;
      REG_COUNT:    rd_data = count_q;
      REG_STATUS:   rd_data = {14'd0, overrun_q, pending_q};
      default:      rd_data = '0;
    endcase
  end

  // Bus writes override timer updates, but a match always sets PENDING last.
  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    pre_d      = (!en_q || tick) ? 16'd0 : pre_q + 16'd1;
    if (tick) begin
      if (!match)      count_d = count_q + 16'd1;
      else if (auto_q) count_d = 16'd0;
      else             en_d    = 1'b0;
    end
    if (reg_wr) begin
      case (wr_off)
        REG_CTRL: begin
          en_d   = wr_data[CTRL_EN];
          auto_d = wr_data[CTRL_AUTO];
          ie_d   = wr_data[CTRL_IE];
        end
        REG_PRESCALE: prescale_d = wr_data;
        REG_COMPARE:  compare_d  = wr_data;
        REG_COUNT:    count_d    = wr_data;
        REG_STATUS: begin
          if (wr_data[STAT_PENDING]) pending_d = 1'b0;
          if (wr_data[STAT_OVERRUN]) overrun_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (ack) pending_d = 1'b0;
    if (match) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      pre_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      pre_q      <= pre_d;
      irq_q      <= pending_q & ie_q;
    end
  end

endmodule

// File: tb/tb_io_timer_irq.sv
// Directed bench for io_timer_irq: register access, match timing, overrun,
// acknowledge paths, one-shot mode and same-cycle collisions.
module tb_io_timer_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_address, io_wdata, io_rdata;
  logic        io_wr, io_rd, io_rvalid, interrupt;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] rdat;
  logic        rvld;

  io_timer_irq dut (
    .clk(clk), .reset(reset), .io_address(io_address), .io_wdata(io_wdata),
    .io_wr(io_wr), .io_rd(io_rd), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1ns after an edge; the write commits on the second following edge.
  task automatic bus_wr(input logic [15:0] addr, input logic [15:0] data);
    io_address = addr;
    io_wdata   = data;
    io_wr      = 1'b1;
    step(1);
    io_wr = 1'b0;
    step(1);
  endtask

  task automatic bus_rd(input logic [15:0] addr);
    io_address = addr;
    io_rd      = 1'b1;
    step(1);
    rdat  = io_rdata;
    rvld  = io_rvalid;
    io_rd = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus_rd(addr);
    check(tag, rdat, exp);
    check({tag, "_vld"}, 16'(rvld), 16'd1);
  endtask

  initial begin
    reset = 1'b0; io_address = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step(1);
    check("rst_rvalid", 16'(io_rvalid), 16'd0);
    check("rst_irq", 16'(interrupt), 16'd0);
    check("rst_rdata", io_rdata, 16'h0000);
    check_reg("rst_ctrl", 16'h0010, 16'h0000);
    check_reg("rst_pre", 16'h0011, 16'h0000);
    check_reg("rst_cmp", 16'h0012, 16'h0000);
    check_reg("rst_cnt", 16'h0013, 16'h0000);
    check_reg("rst_stat", 16'h0014, 16'h0000);
    bus_rd(16'h0015);
    check("oow_hi_vld", 16'(rvld), 16'd0);
    bus_rd(16'h000F);
    check("oow_lo_vld", 16'(rvld), 16'd0);

    // Auto-reload: tick every 4 clocks, match on the third tick.
    bus_wr(16'h0011, 16'd3);
    bus_wr(16'h0012, 16'd2);
    bus_wr(16'h0010, 16'h0007);
    step(11);
    check("irq_e11", 16'(interrupt), 16'd0);
    step(1);
    check("irq_e12", 16'(interrupt), 16'd0);
    step(1);
    check("irq_e13", 16'(interrupt), 16'd1);
    check_reg("stat_match1", 16'h0014, 16'h0001);
    check_reg("cnt_after_match", 16'h0013, 16'h0000);
    step(9);
    check_reg("stat_overrun", 16'h0014, 16'h0003);
    bus_wr(16'h0014, 16'h0002);
    check_reg("stat_w1c_ovr", 16'h0014, 16'h0001);

    // Acknowledge: interrupt drops two clocks after io_wr falls.
    bus_wr(16'h55AA, 16'h1234);
    check("irq_ack_e1", 16'(interrupt), 16'd1);
    step(1);
    check("irq_ack_e2", 16'(interrupt), 16'd0);
    check_reg("stat_after_ack", 16'h0014, 16'h0000);
    step(5);
    check("irq_match3", 16'(interrupt), 16'd1);
    bus_wr(16'h55AB, 16'h0000);
    step(2);
    check("irq_bad_ack", 16'(interrupt), 16'd1);
    bus_wr(16'h0010, 16'h0000);
    bus_wr(16'h0014, 16'h0003);
    step(2);
    check("irq_w1c", 16'(interrupt), 16'd0);

    // One-shot: prescale 0, compare 1.
    bus_wr(16'h0013, 16'd0);
    bus_wr(16'h0011, 16'd0);
    bus_wr(16'h0012, 16'd1);
    bus_wr(16'h0010, 16'h0005);
    step(4);
    check("irq_oneshot", 16'(interrupt), 16'd1);
    check_reg("ctrl_oneshot", 16'h0010, 16'h0004);
    check_reg("cnt_oneshot", 16'h0013, 16'h0001);
    check_reg("stat_oneshot", 16'h0014, 16'h0001);

    // ACK commit lands on the match cycle: the match wins.
    bus_wr(16'h0014, 16'h0003);
    bus_wr(16'h0013, 16'd0);
    bus_wr(16'h0010, 16'h0005);
    bus_wr(16'h55AA, 16'h0000);
    step(2);
    check_reg("stat_ack_vs_match", 16'h0014, 16'h0001);

    // COUNT write on a tick cycle: the written value wins.
    bus_wr(16'h0010, 16'h0000);
    bus_wr(16'h0014, 16'h0003);
    bus_wr(16'h0012, 16'h00FF);
    bus_wr(16'h0011, 16'd3);
    bus_wr(16'h0013, 16'd0);
    bus_wr(16'h0010, 16'h0001);
    step(2);
    bus_wr(16'h0013, 16'h0050);
    check_reg("cnt_wr_vs_tick", 16'h0013, 16'h0050);
    step(3);
    check_reg("cnt_next_tick", 16'h0013, 16'h0051);

    // Reset during a write discards the latched transfer.
    io_address = 16'h0012; io_wdata = 16'h1234; io_wr = 1'b1;
    step(1);
    reset = 1'b0;
    #1 io_wr = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    check_reg("cmp_after_rst_wr", 16'h0012, 16'h0000);
    check_reg("ctrl_after_rst", 16'h0010, 16'h0000);
    check("irq_after_rst", 16'(interrupt), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
